rr_out_sched: RTL and testbench



---
 rtl/rr_out_sched_pkg.sv | 18 +
 rtl/rr_out_sched_if.sv | 14 +
 rtl/rr_out_sched_pick.sv | 28 ++
 rtl/rr_out_sched.sv | 126 ++++++++++++
 tb/tb_rr_out_sched.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/rr_out_sched_pkg.sv
// Shared definitions for the FT2232 output path: scheduler state encoding and
// the index-width helper used by the scheduler and the output mux.
package rr_out_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  localparam int unsigned CUR_SRC_W = 4;

  // Width of an index into n items; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_out_sched_if.sv
// Writer-side handshake of the output mux: writers raise req, the scheduler
// answers with a one-hot sel, and the selected writer drives data.
interface rr_out_sched_if #(
  parameter int unsigned N_SRCS = 4
);

  logic [7:0]        data;
  logic [N_SRCS-1:0] req;
  logic [N_SRCS-1:0] sel;

  modport master (output data, output req, input sel);
  modport slave  (input data, input req, output sel);

endinterface

// File: rtl/rr_out_sched_pick.sv
// Rotate-priority picker: returns the first set request at or after ptr_i,
// wrapping modulo N_SRCS.
module rr_pick
  import rr_out_sched_pkg::*;
#(
  parameter int unsigned N_SRCS = 4,
  localparam int unsigned IW    = idx_w(N_SRCS)
) (
  input  logic [N_SRCS-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < N_SRCS; k++) begin
      logic [IW-1:0] j;
      j = IW'((32'(ptr_i) + k) % N_SRCS);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        idx_o = j;
      end
    end
  end

endmodule

// File: rtl/rr_out_sched.sv
// Round-robin scheduler sharing the FT2232 transmit byte path among writers,
// with a per-grant burst limit and an ack watchdog.
module rr_out_sched
  import rr_out_sched_pkg::*;
#(
  parameter int unsigned N_SRCS      = 4,
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  rr_out_sched_if.slave        omux,
  output logic [7:0]           out_o,
  output logic                 out_req_o,
  input  logic                 out_ack_i,
  output logic [CUR_SRC_W-1:0] cur_src_o,
  output logic                 busy_o,
  output logic                 timeout_o,
  input  logic                 timeout_clr_i
);

  localparam int unsigned IW        = idx_w(N_SRCS);
  localparam int unsigned WDW       = idx_w(ACK_TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(ACK_TIMEOUT - 1);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);

  state_e            state_q, state_d;
  logic [IW-1:0]     cur_src_q, cur_src_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [7:0]        burst_q, burst_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              timeout_q, timeout_d;

  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [N_SRCS-1:0] cur_mask;
  logic [IW-1:0]     ptr_next;
  logic              others;
  logic              timeout_set;

  rr_pick #(.N_SRCS(N_SRCS)) u_pick (
    .req_i (omux.req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign cur_mask = N_SRCS'(1) << cur_src_q;
  assign others   = |(omux.req & ~cur_mask);
  assign ptr_next = (cur_src_q == IW'(N_SRCS - 1)) ? '0 : cur_src_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    ptr_d       = ptr_q;
    burst_d     = burst_q;
    wd_d        = wd_q;
    timeout_set = 1'b0;
    omux.sel    = '0;
    out_req_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          cur_src_d = pick_idx;
          burst_d   = '0;
          state_d   = ST_SEND;
        end
      end
      ST_SEND: begin
        omux.sel  = cur_mask;
        out_req_o = 1'b1;
        // A writer that let go of req has abandoned the strobe; end the grant.
        if (!omux.req[cur_src_q]) begin
          ptr_d   = ptr_next;
          state_d = ST_IDLE;
        end else begin
          if (burst_q != BURST_MAX) burst_d = burst_q + 8'd1;
          wd_d    = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (out_ack_i) begin
          if (burst_q == BURST_MAX && others) begin
            ptr_d   = ptr_next;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else if (wd_q == WD_LAST) begin
          timeout_set = 1'b1;
          ptr_d       = ptr_next;
          state_d     = ST_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    timeout_d = timeout_set ? 1'b1 : (timeout_clr_i ? 1'b0 : timeout_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cur_src_q <= '0;
      ptr_q     <= '0;
      burst_q   <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_src_q <= cur_src_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign out_o     = omux.data;
  assign busy_o    = (state_q != ST_IDLE);
  assign cur_src_o = CUR_SRC_W'(cur_src_q);
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_out_sched.sv
// Directed bench for rr_out_sched (N_SRCS=4, MAX_BURST=4, ACK_TIMEOUT=8);
// expected values are hand-derived cycle by cycle.
module tb_rr_out_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       ack;
  logic       clr;
  logic [7:0] out;
  logic       out_req;
  logic [3:0] cur;
  logic       busy;
  logic       tmo;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned g_src [3] = '{0, 3, 0};

  rr_out_sched_if #(.N_SRCS(4)) omux ();

  rr_out_sched #(
    .N_SRCS      (4),
    .MAX_BURST   (4),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .omux          (omux),
    .out_o         (out),
    .out_req_o     (out_req),
    .out_ack_i     (ack),
    .cur_src_o     (cur),
    .busy_o        (busy),
    .timeout_o     (tmo),
    .timeout_clr_i (clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Settles combinational outputs, then checks the handshake view of one cycle.
  task automatic expect_st(input string tag, input logic [3:0] sel, input logic oreq,
                           input logic bsy, input logic [3:0] src);
    #1;
    chk({tag, ".sel"},     32'(omux.sel), 32'(sel));
    chk({tag, ".out_req"}, 32'(out_req),  32'(oreq));
    chk({tag, ".busy"},    32'(busy),     32'(bsy));
    if (bsy) chk({tag, ".cur_src"}, 32'(cur), 32'(src));
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    reset     = 1'b1;
    ack       = 1'b0;
    clr       = 1'b0;
    omux.req  = '0;
    omux.data = '0;

    tick();
    expect_st("reset", 4'b0000, 1'b0, 1'b0, 4'd0);
    chk("reset.cur_src", 32'(cur), 32'd0);
    chk("reset.timeout", 32'(tmo), 32'd0);
    reset = 1'b0;

    // Sources 0 and 3 streaming with immediate ack: 0 x4, 3 x4, 0 x4.
    ack      = 1'b1;
    omux.req = 4'b1001;
    for (int g = 0; g < 3; g++) begin
      for (int b = 0; b < 4; b++) begin
        tick();
        omux.data = 8'(16 * g + b);
        expect_st("burst.send", 4'(1 << g_src[g]), 1'b1, 1'b1, 4'(g_src[g]));
        chk("burst.data", 32'(out), 32'(16 * g + b));
        tick();
        expect_st("burst.wait", 4'b0000, 1'b0, 1'b1, 4'(g_src[g]));
      end
      tick();
      if (g == 2) omux.req = '0;
      expect_st("burst.idle", 4'b0000, 1'b0, 1'b0, 4'd0);
    end

    // ptr=1 now: get ptr=2 by granting 1 and dropping its req during SEND.
    omux.req = 4'b0010;
    tick();
    omux.req = 4'b0000;
    expect_st("p2.send", 4'b0010, 1'b1, 1'b1, 4'd1);
    tick();
    expect_st("p2.idle", 4'b0000, 1'b0, 1'b0, 4'd0);

    // ptr=2 with 1 and 2 requesting: 2 wins, then streams A1..A3 alone.
    omux.req = 4'b0110;
    tick();
    omux.req  = 4'b0100;
    omux.data = 8'hA1;
    expect_st("prio.send", 4'b0100, 1'b1, 1'b1, 4'd2);
    chk("prio.data1", 32'(out), 32'hA1);
    tick();
    expect_st("single.wait1", 4'b0000, 1'b0, 1'b1, 4'd2);
    tick();
    omux.data = 8'hA2;
    expect_st("single.send2", 4'b0100, 1'b1, 1'b1, 4'd2);
    chk("single.data2", 32'(out), 32'hA2);
    tick();
    expect_st("single.wait2", 4'b0000, 1'b0, 1'b1, 4'd2);
    tick();
    omux.data = 8'hA3;
    expect_st("single.send3", 4'b0100, 1'b1, 1'b1, 4'd2);
    chk("single.data3", 32'(out), 32'hA3);
    tick();
    omux.req = 4'b0000;
    expect_st("single.wait3", 4'b0000, 1'b0, 1'b1, 4'd2);
    tick();
    expect_st("drop.send", 4'b0100, 1'b1, 1'b1, 4'd2);
    tick();
    expect_st("drop.idle", 4'b0000, 1'b0, 1'b0, 4'd0);

    // ptr must now be 3: with 2 and 3 requesting, 3 is granted.
    omux.req = 4'b1100;
    tick();
    ack      = 1'b0;
    omux.req = 4'b1000;
    expect_st("ptr3.send", 4'b1000, 1'b1, 1'b1, 4'd3);

    // Never ack: timeout_o rises 8 cycles after WAIT_ACK entry.
    tick();
    for (int i = 0; i < 8; i++) begin
      expect_st("wd.wait", 4'b0000, 1'b0, 1'b1, 4'd3);
      chk("wd.timeout_low", 32'(tmo), 32'd0);
      tick();
    end
    expect_st("wd.idle", 4'b0000, 1'b0, 1'b0, 4'd0);
    chk("wd.timeout_high", 32'(tmo), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr.timeout", 32'(tmo), 32'd0);
    expect_st("clr.send", 4'b1000, 1'b1, 1'b1, 4'd3);

    // Ack on the last watchdog cycle wins over the timeout.
    tick();
    for (int i = 0; i < 7; i++) begin
      expect_st("ackwin.wait", 4'b0000, 1'b0, 1'b1, 4'd3);
      tick();
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    expect_st("ackwin.send", 4'b1000, 1'b1, 1'b1, 4'd3);
    chk("ackwin.timeout", 32'(tmo), 32'd0);

    // Clear held while the timeout fires: set wins.
    tick();
    clr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expect_st("setwin.wait", 4'b0000, 1'b0, 1'b1, 4'd3);
      tick();
    end
    clr      = 1'b0;
    omux.req = 4'b0001;
    chk("setwin.timeout", 32'(tmo), 32'd1);
    chk("setwin.busy", 32'(busy), 32'd0);

    // Move ptr to 1, grant 1, then reset in WAIT_ACK with 0 and 1 requesting.
    tick();
    omux.req = 4'b0000;
    expect_st("pre.send0", 4'b0001, 1'b1, 1'b1, 4'd0);
    tick();
    omux.req = 4'b0010;
    expect_st("pre.idle", 4'b0000, 1'b0, 1'b0, 4'd0);
    tick();
    expect_st("pre.send1", 4'b0010, 1'b1, 1'b1, 4'd1);
    tick();
    omux.req = 4'b0011;
    reset    = 1'b1;
    expect_st("pre.wait1", 4'b0000, 1'b0, 1'b1, 4'd1);
    chk("pre.timeout", 32'(tmo), 32'd1);
    tick();
    expect_st("rst2", 4'b0000, 1'b0, 1'b0, 4'd0);
    chk("rst2.cur_src", 32'(cur), 32'd0);
    chk("rst2.timeout", 32'(tmo), 32'd0);
    reset = 1'b0;
    tick();
    expect_st("rst2.grant", 4'b0001, 1'b1, 1'b1, 4'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
